// File: rtl/systolic_drain.sv
// -----------------------------------------------------------------------------
// systolic_drain
//
// Result drain stage behind the FP-INT MAC array. A rising edge on `done`
// snapshots every PE's (exponent, fixed-point accumulator) pair. Each pair is
// then converted to IEEE FP16 (truncating, no denormals, saturating at
// +/-65504) and the words are streamed out in PE order over valid/ready.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-low reset
//   done       array results valid (level); only its rising edge captures
//   exp_in     N*N x 5-bit PE exponents, PE k at [5k+4:5k]
//   acc_in     N*N x ACC_WIDTH signed accumulators, PE k at slice k
//   out_valid  out_* holds a converted word
//   out_ready  consumer accepts the word
//   out_data   FP16 result
//   out_idx    PE index of the word (row*N + col)
//   out_last   word belongs to the final PE
//   out_sat    word was saturated to the largest finite FP16
//   busy       a drain is in progress
// -----------------------------------------------------------------------------
module systolic_drain #(
   parameter int ACC_WIDTH = 32,
   parameter int N         = 2,
   parameter int FRAC_BITS = 10,
   parameter int IDX_W     = (N * N > 1) ? $clog2(N * N) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       done,
   input  logic [N*N*5-1:0]           exp_in,
   input  logic [N*N*ACC_WIDTH-1:0]   acc_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [15:0]                out_data,
   output logic [IDX_W-1:0]           out_idx,
   output logic                       out_last,
   output logic                       out_sat,
   output logic                       busy
);

   localparam int NUM = N * N;

   typedef enum logic [1:0] {IDLE, CONV, SEND} state_t;

   state_t                 state, state_next;
   logic                   done_q;
   logic [IDX_W-1:0]       idx;
   logic [4:0]             exp_buf [NUM];
   logic [ACC_WIDTH-1:0]   acc_buf [NUM];
   logic [4:0]             exp_w   [NUM];
   logic [ACC_WIDTH-1:0]   acc_w   [NUM];

   logic                   capture;
   logic                   load_out;
   logic                   advance;

   logic [15:0]            conv_data;
   logic                   conv_sat;

   // Unpack the flattened array buses into per-PE views.
   generate
      for (genvar gi = 0; gi < NUM; gi++) begin : g_unpack
         assign exp_w[gi] = exp_in[5*gi +: 5];
         assign acc_w[gi] = acc_in[ACC_WIDTH*gi +: ACC_WIDTH];
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Fixed-point to FP16 conversion of the currently selected PE.
   // ---------------------------------------------------------------------
   logic [ACC_WIDTH-1:0]   cur_acc;
   logic [4:0]             cur_exp;
   logic                   sign;
   logic [ACC_WIDTH-1:0]   mag;
   logic [ACC_WIDTH-1:0]   aligned;
   int                     msb;
   int                     f_val;

   always_comb begin
      cur_acc   = acc_buf[idx];
      cur_exp   = exp_buf[idx];
      sign      = cur_acc[ACC_WIDTH-1];
      // Two's-complement negate; the most negative value maps onto its own
      // bit pattern, which read as unsigned is exactly 2^(ACC_WIDTH-1).
      mag       = sign ? (~cur_acc + 1'b1) : cur_acc;
      msb       = 0;
      for (int b = 0; b < ACC_WIDTH; b++) begin
         if (mag[b]) msb = b;
      end
      f_val     = msb - FRAC_BITS + int'(cur_exp);
      // Place the bit just below the leading one at position 9.
      if (msb >= 10) aligned = mag >> (msb - 10);
      else           aligned = mag << (10 - msb);
      conv_data = 16'h0000;
      conv_sat  = 1'b0;
      if (mag == '0) begin
         conv_data = 16'h0000;
      end else if (f_val >= 31) begin
         conv_data = {sign, 15'h7BFF};
         conv_sat  = 1'b1;
      end else if (f_val <= 0) begin
         conv_data = {sign, 15'h0000};
      end else begin
         conv_data = {sign, f_val[4:0], aligned[9:0]};
      end
   end

   // ---------------------------------------------------------------------
   // Control FSM: next state and strobes.
   // ---------------------------------------------------------------------
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      load_out   = 1'b0;
      advance    = 1'b0;
      case (state)
         IDLE: begin
            if (done && !done_q) begin
               capture    = 1'b1;
               state_next = CONV;
            end
         end
         CONV: begin
            load_out   = 1'b1;
            state_next = SEND;
         end
         SEND: begin
            if (out_ready) begin
               if (idx == IDX_W'(NUM - 1)) begin
                  state_next = IDLE;
               end else begin
                  advance    = 1'b1;
                  state_next = CONV;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ---------------------------------------------------------------------
   // Datapath registers.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_q   <= 1'b0;
         idx      <= '0;
         out_data <= 16'h0000;
         out_idx  <= '0;
         out_last <= 1'b0;
         out_sat  <= 1'b0;
         for (int k = 0; k < NUM; k++) begin
            exp_buf[k] <= '0;
            acc_buf[k] <= '0;
         end
      end else begin
         done_q <= done;
         if (capture) begin
            idx <= '0;
            for (int k = 0; k < NUM; k++) begin
               exp_buf[k] <= exp_w[k];
               acc_buf[k] <= acc_w[k];
            end
         end
         if (advance) begin
            idx <= idx + 1'b1;
         end
         if (load_out) begin
            out_data <= conv_data;
            out_idx  <= idx;
            out_last <= (idx == IDX_W'(NUM - 1));
            out_sat  <= conv_sat;
         end
      end
   end

   assign out_valid = (state == SEND);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_systolic_drain.sv
module tb_systolic_drain;

   localparam int NUM = 4;
   localparam int AW  = 32;
   localparam int IW  = 2;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                done = 1'b0;
   logic                out_ready = 1'b0;
   logic [NUM*5-1:0]    exp_in = '0;
   logic [NUM*AW-1:0]   acc_in = '0;
   logic                out_valid;
   logic [15:0]         out_data;
   logic [IW-1:0]       out_idx;
   logic                out_last;
   logic                out_sat;
   logic                busy;

   systolic_drain #(.ACC_WIDTH(AW), .N(2), .FRAC_BITS(10)) dut (
      .clk       (clk),
      .rst       (rst),
      .done      (done),
      .exp_in    (exp_in),
      .acc_in    (acc_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .out_sat   (out_sat),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0]   data;
      logic [IW-1:0] idx;
      logic          last;
      logic          sat;
   } word_t;

   word_t sb[$];
   int    tests = 0;
   int    fails = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Reference conversion: value = acc * 2^(exp-15-10) expressed as FP16,
   // truncated, flushed below the normal range, saturated above it.
   // Returns {sat, data}.
   function automatic logic [16:0] ref_conv(logic [31:0] acc, logic [4:0] e);
      longint a, m, frac;
      int     lg, f;
      logic   s;
      logic [4:0] fe;
      a = longint'(signed'(acc));
      s = (a < 0);
      m = s ? -a : a;
      if (m == 0) return 17'h0;
      lg = 0;
      while ((64'sd1 <<< (lg + 1)) <= m) lg++;
      f = lg - 10 + int'(e);
      if (f >= 31) return {1'b1, s, 15'h7BFF};
      if (f <= 0)  return {1'b0, s, 15'h0000};
      frac = ((m <<< 10) >>> lg) - 1024;
      fe   = f[4:0];
      return {1'b0, s, fe, frac[9:0]};
   endfunction

   task automatic set_pe(int k, logic [31:0] a, logic [4:0] e);
      acc_in[k*AW +: AW] = a;
      exp_in[k*5 +: 5]   = e;
   endtask

   function automatic logic [31:0] rand_acc();
      logic [31:0] v;
      v = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) v = -v;
      return v;
   endfunction

   task automatic randomize_pes();
      for (int k = 0; k < NUM; k++) set_pe(k, rand_acc(), 5'($urandom_range(0, 31)));
   endtask

   // Push the expected stream for the current inputs, then raise done.
   task automatic capture(bit hold);
      word_t w;
      logic [16:0] r;
      for (int k = 0; k < NUM; k++) begin
         r      = ref_conv(acc_in[k*AW +: AW], exp_in[k*5 +: 5]);
         w.data = r[15:0];
         w.sat  = r[16];
         w.idx  = IW'(k);
         w.last = (k == NUM - 1);
         sb.push_back(w);
      end
      done = 1'b1;
      @(posedge clk); #1;
      if (!hold) done = 1'b0;
   endtask

   task automatic wait_idle(int budget);
      int c = 0;
      while (busy && c < budget) begin
         @(posedge clk); #1;
         c++;
      end
      check("drain_timeout", {31'd0, busy}, 32'd0);
   endtask

   task automatic drain_random(int budget);
      int c = 0;
      while (busy && c < budget) begin
         out_ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         c++;
      end
      out_ready = 1'b1;
      check("drain_timeout", {31'd0, busy}, 32'd0);
   endtask

   task automatic wait_word(int k, int budget);
      int c = 0;
      while (!(out_valid && out_idx == IW'(k)) && c < budget) begin
         @(posedge clk); #1;
         c++;
      end
      check("wait_word", {29'd0, out_valid, out_idx}, {29'd0, 1'b1, IW'(k)});
   endtask

   task automatic one_cycle_ready();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   // ---------------------------------------------------------------------
   // Monitor: scoreboard pops, handshake stability and word spacing.
   // ---------------------------------------------------------------------
   int    cyc = 0;
   int    last_xfer_cyc = 0;
   bit    mid = 1'b0;
   bit    prev_v = 1'b0;
   bit    prev_x = 1'b0;
   word_t prev_w;

   always @(negedge clk) begin
      word_t cur, e;
      cyc++;
      cur = {out_data, out_idx, out_last, out_sat};
      if (!rst) begin
         prev_v = 1'b0;
         prev_x = 1'b0;
         mid    = 1'b0;
      end else begin
         if (prev_v && !prev_x) begin
            check("valid_hold", {31'd0, out_valid}, 32'd1);
            check("word_stable", {12'd0, cur}, {12'd0, prev_w});
         end
         if (out_valid && !prev_v && mid) begin
            check("word_gap", cyc - last_xfer_cyc, 2);
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_word", {12'd0, cur}, 32'hFFFFFFFF);
            end else begin
               e = sb.pop_front();
               check("out_data", {16'd0, out_data}, {16'd0, e.data});
               check("out_idx",  {30'd0, out_idx},  {30'd0, e.idx});
               check("out_last", {31'd0, out_last}, {31'd0, e.last});
               check("out_sat",  {31'd0, out_sat},  {31'd0, e.sat});
            end
            last_xfer_cyc = cyc;
            mid = !out_last;
         end
         prev_v = out_valid;
         prev_x = out_valid && out_ready;
         prev_w = cur;
      end
   end

   task automatic check_reset_outputs(string tag);
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_data"},  {16'd0, out_data},  32'd0);
      check({tag, "_idx"},   {30'd0, out_idx},   32'd0);
      check({tag, "_last"},  {31'd0, out_last},  32'd0);
      check({tag, "_sat"},   {31'd0, out_sat},   32'd0);
      check({tag, "_busy"},  {31'd0, busy},      32'd0);
   endtask

   initial begin
      #2 rst = 1'b0;
      @(posedge clk); #1;
      check_reset_outputs("reset");
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("post_reset");

      // All PEs at 1.0; done held high through the drain.
      out_ready = 1'b1;
      for (int k = 0; k < NUM; k++) set_pe(k, 32'h00000400, 5'd15);
      capture(1'b1);
      wait_idle(100);
      repeat (3) @(posedge clk);
      #1;
      check("no_retrigger", {31'd0, busy}, 32'd0);
      done = 1'b0;
      @(posedge clk); #1;

      // Mixed signs, tiny value, zero and flush.
      set_pe(0, 32'hFFFF9000, 5'd15);
      set_pe(1, 32'h00000001, 5'd25);
      set_pe(2, 32'h00000000, 5'd9);
      set_pe(3, 32'hFFFFFFFF, 5'd0);
      capture(1'b0);
      wait_idle(100);

      // Saturation at both signs, random ready.
      set_pe(0, 32'h7FFFFFFF, 5'd15);
      set_pe(1, 32'h80000000, 5'd15);
      set_pe(2, rand_acc(), 5'd31);
      set_pe(3, rand_acc(), 5'd31);
      capture(1'b0);
      drain_random(200);

      // Backpressure on idx 1 for 5 cycles.
      randomize_pes();
      out_ready = 1'b0;
      capture(1'b0);
      wait_word(0, 20);
      one_cycle_ready();
      wait_word(1, 20);
      repeat (5) @(posedge clk);
      #1;
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_idx", {30'd0, out_idx}, 32'd1);
      out_ready = 1'b1;
      wait_idle(100);

      // Second done during SEND of idx 1 is ignored; a later one drains it.
      randomize_pes();
      capture(1'b0);
      wait_word(1, 20);
      randomize_pes();
      done = 1'b1;
      @(posedge clk); #1;
      done = 1'b0;
      wait_idle(100);
      @(posedge clk); #1;
      capture(1'b0);
      wait_idle(100);

      // Random drains with random backpressure.
      for (int t = 0; t < 8; t++) begin
         randomize_pes();
         capture(1'b0);
         drain_random(300);
         @(posedge clk); #1;
      end

      // Reset while idx 2 is on the output.
      randomize_pes();
      out_ready = 1'b0;
      capture(1'b0);
      wait_word(0, 20);
      one_cycle_ready();
      wait_word(1, 20);
      one_cycle_ready();
      wait_word(2, 20);
      #2 rst = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      sb.delete();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      randomize_pes();
      capture(1'b0);
      wait_idle(100);

      repeat (3) @(posedge clk);
      #1;
      check("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
